branch_predict_unit: RTL and testbench

- Parametrised successor to the combinational ID-stage branch comparator.
- Resolves MIPS conditional branches (beq, bne, bgez, bgtz, blez, bltz) in ID.
- Adds a PC-indexed branch history table (BHT) of 2-bit saturating counters that predicts in IF.
- Carries each prediction into ID, flags mispredicts with a redirect PC, and keeps saturating performance counters.

---
 rtl/branch_predict_unit.sv | 129 ++++++++++++
 tb/tb_branch_predict_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// ID-stage branch resolver with an IF-stage 2-bit-counter branch history table.
// Predicts in IF from a PC-indexed BHT, carries the prediction into ID,
// resolves the six MIPS conditional branches there and flags mispredicts
// with the correct next fetch PC. Saturating counters track branches and misses.
module branch_predict_unit #(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_W     = $clog2(BHT_DEPTH),
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [WIDTH-1:0] if_pc,
    output logic             pred_taken,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [5:0]       op,
    input  logic [4:0]       rt,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] id_target,
    output logic             is_branch,
    output logic             actual_taken,
    output logic             mispredict,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    // 2-bit saturating counters; bit 1 is the taken prediction.
    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] id_idx;
    logic             pred_id;
    logic             cond;
    logic             resolve;
    logic [1:0]       cur_ctr;
    logic [1:0]       next_ctr;
    logic             rs_neg;
    logic             rs_zero;
    logic             unused_bits;

    // Word-aligned PCs: drop the byte offset, upper bits alias onto the table.
    assign if_idx = if_pc[IDX_W+1:2];
    assign id_idx = id_pc[IDX_W+1:2];
    assign unused_bits = ^{if_pc[1:0], if_pc[WIDTH-1:IDX_W+2]};

    // No write bypass: an update in this cycle is seen by the read next cycle.
    assign pred_taken = bht[if_idx][1];

    assign rs_neg  = rs_data[WIDTH-1];
    assign rs_zero = (rs_data == '0);

    // Decode the branch opcode and evaluate its condition.
    always_comb begin
        is_branch = 1'b0;
        cond      = 1'b0;
        case (op)
            OP_BEQ:  begin is_branch = 1'b1; cond = (rs_data == rt_data); end
            OP_BNE:  begin is_branch = 1'b1; cond = (rs_data != rt_data); end
            OP_BLEZ: begin is_branch = 1'b1; cond = rs_neg | rs_zero; end
            OP_BGTZ: begin is_branch = 1'b1; cond = ~rs_neg & ~rs_zero; end
            OP_REGIMM: begin
                if (rt == RT_BGEZ) begin
                    is_branch = 1'b1;
                    cond      = ~rs_neg;
                end else if (rt == RT_BLTZ) begin
                    is_branch = 1'b1;
                    cond      = rs_neg;
                end
            end
            default: begin is_branch = 1'b0; cond = 1'b0; end
        endcase
    end

    assign actual_taken = is_branch & id_valid & cond;
    assign mispredict   = id_valid & is_branch & (actual_taken != pred_id);
    assign resolve      = id_valid & is_branch & ~stall;
    // Not-taken skips the delay slot; wraps modulo 2^WIDTH.
    assign redirect_pc  = actual_taken ? id_target : (id_pc + WIDTH'(8));

    assign cur_ctr = bht[id_idx];

    // Saturating step of the counter being trained.
    always_comb begin
        next_ctr = cur_ctr;
        if (actual_taken) begin
            if (cur_ctr != 2'b11) next_ctr = cur_ctr + 2'b01;
        end else begin
            if (cur_ctr != 2'b00) next_ctr = cur_ctr - 2'b01;
        end
    end

    // BHT training on resolve; reset puts every entry at weakly not-taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (resolve) begin
            bht[id_idx] <= next_ctr;
        end
    end

    // Carry the IF prediction into ID alongside the instruction.
    always_ff @(posedge clk) begin
        if (reset)       pred_id <= 1'b0;
        else if (!stall) pred_id <= pred_taken;
    end

    // Saturating performance counters, stepped once per resolved branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else if (resolve) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispredict && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed plan steps followed by randomized
// traffic, all checked against a table-of-integers reference model.
module tb_branch_predict_unit;

    localparam int W    = 32;
    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic          clk = 1'b0;
    logic          reset, stall, id_valid;
    logic [W-1:0]  if_pc, id_pc, rs_data, rt_data, id_target;
    logic [5:0]    op;
    logic [4:0]    rt;
    logic          pred_taken, is_branch, actual_taken, mispredict;
    logic [W-1:0]  redirect_pc;
    logic [CW-1:0] branch_cnt, miss_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: counter values 0..3, carried prediction, counts.
    int bht_m [64];
    int pred_m;
    int bcnt_m, mcnt_m;

    branch_predict_unit #(.WIDTH(W), .BHT_DEPTH(64), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .if_pc(if_pc),
        .pred_taken(pred_taken), .id_valid(id_valid), .id_pc(id_pc),
        .op(op), .rt(rt), .rs_data(rs_data), .rt_data(rt_data),
        .id_target(id_target), .is_branch(is_branch),
        .actual_taken(actual_taken), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [W-1:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic bit model_is_branch(input logic [5:0] o, input logic [4:0] r);
        return (o == 6'd4) || (o == 6'd5) || (o == 6'd6) || (o == 6'd7) ||
               (o == 6'd1 && (r == 5'd0 || r == 5'd1));
    endfunction

    function automatic bit model_cond(input logic [5:0] o, input logic [4:0] r,
                                      input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        sa = signed'(a);
        case (o)
            6'd4: return a == b;
            6'd5: return a != b;
            6'd6: return sa <= 0;
            6'd7: return sa > 0;
            6'd1: return (r == 5'd1) ? (sa >= 0) : (sa < 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        pred_m = 0;
        bcnt_m = 0;
        mcnt_m = 0;
    endtask

    // Apply reset while a stalled, resolving branch sits in ID.
    task automatic do_reset();
        reset = 1'b1; stall = 1'b1; id_valid = 1'b1; op = 6'd4; rt = 5'd0;
        rs_data = 32'd7; rt_data = 32'd7; id_pc = 32'h3000; id_target = 32'h3100;
        if_pc = 32'h3000;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0; stall = 1'b0; id_valid = 1'b0;
    endtask

    // One clock: drive, check every output against the model, clock, advance model.
    task automatic cycle(input bit st, input bit v, input logic [W-1:0] ipc,
                         input logic [W-1:0] dpc, input logic [5:0] o, input logic [4:0] r,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] tgt);
        bit br, tk, e_pred, e_mis;
        logic [W-1:0] e_red;
        stall = st; id_valid = v; if_pc = ipc; id_pc = dpc; op = o; rt = r;
        rs_data = a; rt_data = b; id_target = tgt;
        #1;
        br     = model_is_branch(o, r);
        tk     = br && v && model_cond(o, r, a, b);
        e_pred = bht_m[idx_of(ipc)] >= 2;
        e_mis  = v && br && (tk != pred_m);
        e_red  = tk ? tgt : dpc + 32'd8;
        check("pred_taken",   pred_taken,   e_pred);
        check("is_branch",    is_branch,    br);
        check("actual_taken", actual_taken, tk);
        check("mispredict",   mispredict,   e_mis);
        check("redirect_pc",  redirect_pc,  e_red);
        check("branch_cnt",   branch_cnt,   bcnt_m);
        check("miss_cnt",     miss_cnt,     mcnt_m);
        @(posedge clk);
        if (!st) begin
            pred_m = e_pred;
            if (v && br) begin
                int k;
                k = idx_of(dpc);
                bht_m[k] = tk ? ((bht_m[k] < 3) ? bht_m[k] + 1 : 3)
                              : ((bht_m[k] > 0) ? bht_m[k] - 1 : 0);
                if (bcnt_m < CMAX) bcnt_m++;
                if (e_mis && mcnt_m < CMAX) mcnt_m++;
            end
        end
        #1;
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [W-1:0] pick_pc();
        case ($urandom_range(0, 4))
            0: return 32'h0000;
            1: return 32'h0100;
            2: return 32'h3000;
            3: return 32'h4000;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        reset = 1'b0; stall = 1'b0; id_valid = 1'b0; if_pc = '0; id_pc = '0;
        op = '0; rt = '0; rs_data = '0; rt_data = '0; id_target = '0;
        do_reset();

        // Reset state with a bubble in ID.
        cycle(0, 0, 32'h3000, 32'h0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        check("rst_branch_cnt", branch_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);

        // beq taken at 0x3000 against a not-taken carried prediction.
        cycle(0, 1, 32'h3000, 32'h3000, 6'd4, 5'd0, 32'd5, 32'd5, 32'h3040);
        check("beq_branch_cnt", branch_cnt, 1);
        check("beq_miss_cnt", miss_cnt, 1);
        stall = 1'b0; id_valid = 1'b0; if_pc = 32'h3000;
        #1;
        check("beq_trained_pred", pred_taken, 1);

        // Counter saturation via bgtz taken, then one bltz not-taken.
        for (int i = 0; i < 4; i++)
            cycle(0, 1, 32'h4000, 32'h4000, 6'd7, 5'd0, 32'd1, 32'd0, 32'h4400);
        cycle(0, 1, 32'h4000, 32'h4000, 6'd1, 5'd0, 32'd1, 32'd0, 32'h4400);
        cycle(0, 0, 32'h4000, 32'h0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // Signed boundary cases and the delay-slot skip, including wraparound.
        cycle(0, 1, 32'h0, 32'h5000, 6'd1, 5'd1, 32'h8000_0000, 32'd0, 32'h5100);
        cycle(0, 1, 32'h0, 32'h5004, 6'd6, 5'd0, 32'h0, 32'd0, 32'h5100);
        cycle(0, 1, 32'h0, 32'h5008, 6'd1, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h5100);
        cycle(0, 1, 32'h0, 32'h500C, 6'd5, 5'd0, 32'd9, 32'd9, 32'h5100);
        cycle(0, 1, 32'h0, 32'hFFFF_FFF8, 6'd5, 5'd0, 32'd3, 32'd3, 32'h5100);
        cycle(0, 1, 32'h0, 32'h5010, 6'd1, 5'd2, 32'd0, 32'd0, 32'h5100);

        // Stall: three held cycles with a resolving branch, then one release.
        for (int i = 0; i < 3; i++)
            cycle(1, 1, 32'h6000, 32'h6000, 6'd5, 5'd0, 32'd1, 32'd2, 32'h6100);
        cycle(0, 1, 32'h6000, 32'h6000, 6'd5, 5'd0, 32'd1, 32'd2, 32'h6100);
        cycle(0, 0, 32'h6000, 32'h0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // Aliasing 0x0000/0x0100 and same-cycle read of the written index.
        cycle(0, 1, 32'h0100, 32'h0000, 6'd4, 5'd0, 32'd1, 32'd1, 32'h0040);
        cycle(0, 1, 32'h0100, 32'h0100, 6'd4, 5'd0, 32'd1, 32'd1, 32'h0040);
        cycle(0, 0, 32'h0000, 32'h0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // Randomized traffic; long enough to drive branch_cnt into saturation.
        for (int n = 0; n < 800; n++) begin
            logic [5:0] o;
            logic [4:0] r;
            logic [W-1:0] a, b;
            int sel;
            sel = $urandom_range(0, 9);
            r = 5'($urandom_range(0, 31));
            a = pick_val();
            b = pick_val();
            case (sel)
                0: o = 6'd4;
                1: o = 6'd5;
                2: o = 6'd6;
                3: o = 6'd7;
                4: begin o = 6'd1; r = 5'd1; end
                5: begin o = 6'd1; r = 5'd0; end
                6: o = 6'h23;
                7: begin o = 6'd1; r = 5'd2; end
                8: begin o = 6'd4; b = a; end
                default: begin o = 6'd5; b = a; end
            endcase
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 19) != 0,
                  pick_pc(), pick_pc(), o, r, a, b, $urandom & 32'hFFFF_FFFC);
        end
        check("branch_cnt_sat", branch_cnt, CMAX);
        cycle(0, 1, 32'h3000, 32'h3000, 6'd4, 5'd0, 32'd1, 32'd1, 32'h3040);
        check("branch_cnt_hold", branch_cnt, CMAX);

        // Mid-stream reset while stalled with a pending update.
        do_reset();
        check("rst2_branch_cnt", branch_cnt, 0);
        check("rst2_miss_cnt", miss_cnt, 0);
        cycle(0, 0, 32'h4000, 32'h0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        cycle(0, 1, 32'h0100, 32'h3000, 6'd4, 5'd0, 32'd1, 32'd1, 32'h3040);
        cycle(0, 0, 32'h3000, 32'h0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        cycle(0, 0, 32'h4000, 32'h0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
